// File: rtl/uart_tx_frame_piso_if.sv
// ============================================================================
// uart_tx_frame_piso_if : valid/ready word handshake into the UART TX serializer
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_frame_piso_if #(
   parameter int DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_frame_piso.sv
// ============================================================================
// uart_tx_frame_piso : one-entry hold + frame PISO; parity bit enabled by `UART_TX_PARITY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_frame_piso #(
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int MSB_FIRST  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   uart_tx_frame_piso_if.slave in_if,
   output logic                tx_out,
   output logic                busy,
   output logic                done
);

`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int               FRAME_N  = 1 + DATA_W + PAR_BITS + STOP_BITS;
   localparam int               CNT_W    = $clog2(FRAME_N);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_N - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic               hold_valid, hold_valid_nxt;
   logic [DATA_W-1:0]  hold_data;
   logic [DATA_W-1:0]  data_ord;
   logic [FRAME_N-1:0] frame_reg, frame_nxt, frame_load;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               tx_reg, tx_nxt;
   logic               done_reg, done_nxt;
   logic               accept, load;

   assign in_if.ready = !hold_valid;
   assign accept      = in_if.valid && !hold_valid;

   // Reorder so that bit 0 of data_ord is always the first data bit on the line.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         always_comb begin
            data_ord = '0;
            for (int i = 0; i < DATA_W; i++) begin
               data_ord[i] = hold_data[DATA_W-1-i];
            end
         end
      end else begin : g_lsb_first
         assign data_ord = hold_data;
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   logic parity;
   assign parity     = (^hold_data) ^ (PARITY_ODD != 0);
   assign frame_load = {{STOP_BITS{1'b1}}, parity, data_ord, 1'b0};
`else
   // PARITY_ODD is meaningless without the parity bit.
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
   assign frame_load        = {{STOP_BITS{1'b1}}, data_ord, 1'b0};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         frame_reg  <= '1;
         cnt        <= '0;
         tx_reg     <= 1'b1;
         done_reg   <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_valid <= hold_valid_nxt;
         frame_reg  <= frame_nxt;
         cnt        <= cnt_nxt;
         tx_reg     <= tx_nxt;
         done_reg   <= done_nxt;
         if (accept) begin
            hold_data <= in_if.data;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      hold_valid_nxt = hold_valid;
      frame_nxt      = frame_reg;
      cnt_nxt        = cnt;
      done_nxt       = 1'b0;
      load           = 1'b0;

      if (tick) begin
         case (state)
            ST_IDLE: begin
               load = hold_valid;
            end
            ST_SHIFT: begin
               if (cnt != '0) begin
                  frame_nxt = {1'b1, frame_reg[FRAME_N-1:1]};
                  cnt_nxt   = cnt - CNT_W'(1);
               end else begin
                  // Last stop bit ends here; chain straight into a held word.
                  done_nxt = 1'b1;
                  if (hold_valid) begin
                     load = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      if (load) begin
         frame_nxt      = frame_load;
         cnt_nxt        = CNT_LOAD;
         state_nxt      = ST_SHIFT;
         hold_valid_nxt = 1'b0;
      end
      if (accept) begin
         hold_valid_nxt = 1'b1;
      end

      tx_nxt = (state_nxt == ST_SHIFT) ? frame_nxt[0] : 1'b1;
   end

   assign tx_out = tx_reg;
   assign done   = done_reg;
   assign busy   = hold_valid || (state == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_piso.sv
// ============================================================================
// tb_uart_tx_frame_piso : three parameter variants checked against a frame model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_frame_piso;
   localparam int NDUT     = 3;
   localparam int TICK_DIV = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic            clk  = 1'b0;
   logic            rst  = 1'b1;
   logic            tick = 1'b0;
   int              tdiv = 0;
   logic [NDUT-1:0] valid = '0;
   logic [8:0]      data [NDUT] = '{default: '0};
   logic [NDUT-1:0] ready, tx, busy, done;
   int              done_cnt [NDUT] = '{default: 0};
   int              n_checks = 0;
   int              n_fail   = 0;

   uart_tx_frame_piso_if #(.DATA_W(8)) if0 ();
   uart_tx_frame_piso_if #(.DATA_W(8)) if1 ();
   uart_tx_frame_piso_if #(.DATA_W(5)) if2 ();

   assign if0.valid = valid[0];
   assign if0.data  = data[0][7:0];
   assign ready[0]  = if0.ready;
   assign if1.valid = valid[1];
   assign if1.data  = data[1][7:0];
   assign ready[1]  = if1.ready;
   assign if2.valid = valid[2];
   assign if2.data  = data[2][4:0];
   assign ready[2]  = if2.ready;

   uart_tx_frame_piso #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst(rst), .tick(tick), .in_if(if0),
      .tx_out(tx[0]), .busy(busy[0]), .done(done[0]));
   uart_tx_frame_piso #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(1)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .in_if(if1),
      .tx_out(tx[1]), .busy(busy[1]), .done(done[1]));
   uart_tx_frame_piso #(.DATA_W(5), .STOP_BITS(2), .MSB_FIRST(0), .PARITY_ODD(0)) dut2 (
      .clk(clk), .rst(rst), .tick(tick), .in_if(if2),
      .tx_out(tx[2]), .busy(busy[2]), .done(done[2]));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tdiv == TICK_DIV - 1) begin
         tdiv <= 0;
         tick <= 1'b1;
      end else begin
         tdiv <= tdiv + 1;
         tick <= 1'b0;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      end
   end

   function automatic int  cfg_dw  (input int k); return (k == 2) ? 5 : 8; endfunction
   function automatic int  cfg_stop(input int k); return (k == 2) ? 2 : 1; endfunction
   function automatic bit  cfg_msb (input int k); return (k == 1);         endfunction
   function automatic bit  cfg_odd (input int k); return (k == 1);         endfunction
   function automatic int  cfg_n   (input int k); return 1 + cfg_dw(k) + PAR + cfg_stop(k); endfunction

   // Bit i of the result is the i-th bit period on the line.
   function automatic logic [15:0] model_frame(input int k, input logic [8:0] d);
      logic [15:0] f;
      int          pos;
      bit          par;
      int          dw;
      dw  = cfg_dw(k);
      f   = '1;
      f[0] = 1'b0;
      pos = 1;
      par = cfg_odd(k);
      for (int i = 0; i < dw; i++) begin
         f[pos] = cfg_msb(k) ? d[dw-1-i] : d[i];
         par    = par ^ d[i];
         pos++;
      end
      if (PAR == 1) f[pos] = par;
      return f;
   endfunction

   // Call at a negedge; returns at the negedge just after the next tick edge.
   task automatic wait_tick_edge();
      int g = 0;
      while (tick !== 1'b1 && g < 4 * TICK_DIV) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
   endtask

   task automatic wait_start(input int k, output bit ok);
      int g = 0;
      ok = 1'b0;
      while (g < 6 * cfg_n(k) + 8) begin
         wait_tick_edge();
         g++;
         if (tx[k] === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Samples bit periods 1..N after a start bit; sample N is the period after the frame.
   task automatic capture_frame(input int k, output logic [15:0] bits, output logic [15:0] dns);
      bits = '0;
      dns  = '0;
      for (int i = 1; i <= cfg_n(k); i++) begin
         wait_tick_edge();
         bits[i] = tx[k];
         dns[i]  = done[k];
      end
   endtask

   task automatic present(input int k, input logic [8:0] d, output bit ok);
      int g = 0;
      @(negedge clk);
      valid[k] = 1'b1;
      data[k]  = d;
      while (ready[k] !== 1'b1 && g < 40 * TICK_DIV) begin
         @(negedge clk);
         g++;
      end
      ok = (ready[k] === 1'b1);
      @(posedge clk);
   endtask

   task automatic release_in(input int k);
      @(negedge clk);
      valid[k] = 1'b0;
      data[k]  = 9'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         n_checks++;
         if (tx[k] !== 1'b1) begin n_fail++; $display("FAIL reset_tx k=%0d: got %b want 1", k, tx[k]); end
         n_checks++;
         if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d: got %b want 0", k, busy[k]); end
         n_checks++;
         if (done[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done k=%0d: got %b want 0", k, done[k]); end
         n_checks++;
         if (ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready k=%0d: got %b want 1", k, ready[k]); end
      end
      rst = 1'b0;
   endtask

   task automatic test_single(input int k, input logic [8:0] d, input logic [15:0] exp, input string tag);
      int          n;
      int          dc0;
      bit          ok;
      logic [15:0] mask, bits, dns;
      n    = cfg_n(k);
      mask = (16'd1 << n) - 16'd1;
      dc0  = done_cnt[k];
      present(k, d, ok);
      release_in(k);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s accept: got timeout want accept", tag); end
      n_checks++;
      if (busy[k] !== 1'b1 || ready[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_accept: got busy=%b ready=%b want busy=1 ready=0", tag, busy[k], ready[k]);
      end
      wait_tick_edge();
      n_checks++;
      if (tx[k] !== 1'b0) begin n_fail++; $display("FAIL %s start_latency: got tx=%b want 0", tag, tx[k]); end
      n_checks++;
      if (ready[k] !== 1'b1) begin n_fail++; $display("FAIL %s ready_after_load: got %b want 1", tag, ready[k]); end
      capture_frame(k, bits, dns);
      n_checks++;
      if ((bits & mask) !== (exp & mask)) begin
         n_fail++;
         $display("FAIL %s frame: got %h want %h", tag, bits & mask, exp & mask);
      end
      n_checks++;
      if (dns !== (16'd1 << n)) begin n_fail++; $display("FAIL %s done_pos: got %h want %h", tag, dns, 16'd1 << n); end
      n_checks++;
      if (bits[n] !== 1'b1 || busy[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_after: got tx=%b busy=%b want tx=1 busy=0", tag, bits[n], busy[k]);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (done_cnt[k] - dc0 != 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt[k] - dc0); end
   endtask

   task automatic run_stream(input int k, input logic [8:0] words[$], input bit held, input string tag);
      logic [8:0]  expq[$];
      int          n, nw, dc0;
      bit          ok_d, ok_m, started;
      logic [15:0] mask, bits, dns, expf;
      n    = cfg_n(k);
      nw   = words.size();
      mask = (16'd1 << n) - 16'd1;
      dc0  = done_cnt[k];
      @(negedge clk);
      fork
         begin
            foreach (words[i]) begin
               if (!held) repeat ($urandom_range(0, 2 * n * TICK_DIV)) @(negedge clk);
               present(k, words[i], ok_d);
               n_checks++;
               if (!ok_d) begin n_fail++; $display("FAIL %s accept word %0d: got timeout want accept", tag, i); end
               expq.push_back(words[i]);
               if (!held) release_in(k);
            end
            release_in(k);
         end
         begin
            wait_start(k, ok_m);
            started = ok_m;
            for (int f = 0; f < nw; f++) begin
               if (!started) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL %s start frame %0d: got no start bit want start bit", tag, f);
                  break;
               end
               capture_frame(k, bits, dns);
               expf = '0;
               if (expq.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL %s frame %0d: got frame want no frame", tag, f);
               end else begin
                  expf = model_frame(k, expq.pop_front());
               end
               n_checks++;
               if ((bits & mask) !== (expf & mask)) begin
                  n_fail++;
                  $display("FAIL %s frame %0d: got %h want %h", tag, f, bits & mask, expf & mask);
               end
               n_checks++;
               if (dns !== (16'd1 << n)) begin
                  n_fail++;
                  $display("FAIL %s done_pos %0d: got %h want %h", tag, f, dns, 16'd1 << n);
               end
               if (f < nw - 1) begin
                  if (held) begin
                     n_checks++;
                     if (bits[n] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s gap after frame %0d: got tx=%b want 0", tag, f, bits[n]);
                     end
                  end
                  if (bits[n] === 1'b0) begin
                     started = 1'b1;
                  end else begin
                     wait_start(k, ok_m);
                     started = ok_m;
                  end
               end else begin
                  n_checks++;
                  if (bits[n] !== 1'b1 || busy[k] !== 1'b0) begin
                     n_fail++;
                     $display("FAIL %s idle_after: got tx=%b busy=%b want tx=1 busy=0", tag, bits[n], busy[k]);
                  end
               end
            end
         end
      join
      repeat (2) @(negedge clk);
      n_checks++;
      if (done_cnt[k] - dc0 != nw) begin
         n_fail++;
         $display("FAIL %s done_count: got %0d want %0d", tag, done_cnt[k] - dc0, nw);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] q[$];
      q = '{9'h000, 9'h0FF};
      run_stream(0, q, 1'b1, "b2b_00_ff");
   endtask

   task automatic test_random(input int k);
      logic [8:0] q[$];
      for (int i = 0; i < 6; i++) q.push_back(9'($urandom));
      run_stream(k, q, 1'b1, "rand_held");
      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(9'($urandom));
      run_stream(k, q, 1'b0, "rand_gap");
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int dc0;
      bit saw_low = 1'b0;
      present(0, 9'h0C3, ok);
      release_in(0);
      wait_tick_edge();
      present(0, 9'h03C, ok);
      release_in(0);
      n_checks++;
      if (!ok || ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid held_word: got ok=%b ready=%b want ok=1 ready=0", ok, ready[0]);
      end
      repeat (4) wait_tick_edge();
      dc0 = done_cnt[0];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid state: got tx=%b busy=%b ready=%b want 1 0 1", tx[0], busy[0], ready[0]);
      end
      for (int i = 0; i < cfg_n(0) + 2; i++) begin
         wait_tick_edge();
         if (tx[0] !== 1'b1) saw_low = 1'b1;
      end
      n_checks++;
      if (saw_low) begin n_fail++; $display("FAIL rst_mid line_idle: got low bit want idle line"); end
      n_checks++;
      if (done_cnt[0] != dc0) begin n_fail++; $display("FAIL rst_mid done: got %0d pulses want 0", done_cnt[0] - dc0); end
   endtask

   initial begin
      test_reset();
`ifdef UART_TX_PARITY_EN
      test_single(0, 9'h0A5, 16'h054A, "a5_lsb_even");
      test_single(1, 9'h001, 16'h0500, "01_msb_odd");
      test_single(1, 9'h0A5, 16'h074A, "a5_msb_odd");
      test_single(2, 9'h01F, 16'h01FE, "1f_w5_s2");
`else
      test_single(0, 9'h0A5, 16'h034A, "a5_lsb");
      test_single(1, 9'h001, 16'h0300, "01_msb");
      test_single(1, 9'h0A5, 16'h034A, "a5_msb");
      test_single(2, 9'h01F, 16'h00FE, "1f_w5_s2");
`endif
      test_back_to_back();
      for (int k = 0; k < NDUT; k++) test_random(k);
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire
